inst_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the single-cycle MIPS core's combinational instruction ROM.
//  - Owns the PC and drives the ROM address each cycle.
//  - Buffers fetched words in a 2-entry queue and hands them to decode with a valid/ready handshake.
//  - Accepts jump/branch redirects, which flush the queue.
//  - Sits between the ROM and the decode/control stage.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_queue2.sv | 68 ++++++
 rtl/inst_fetch_ctrl.sv | 73 +++++++
 tb/tb_inst_fetch_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and helpers for the fetch front end
package cpu_pkg;
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0;

    function automatic logic [29:0] pc_word_idx(input logic [31:0] pc);
        return pc[31:2];
    endfunction
endpackage

// File: rtl/fetch_queue2.sv
// rtl/fetch_queue2.sv - two-entry {pc,inst} FIFO; head held in slot 0
module fetch_queue2
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [31:0]       push_pc,
    input  logic [INST_W-1:0] push_inst,
    output logic [31:0]       head_pc,
    output logic [INST_W-1:0] head_inst,
    output logic [1:0]        count
);
    logic [31:0]       pc0, pc1;
    logic [INST_W-1:0] inst0, inst1;
    logic [1:0]        cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc0   <= 32'h0;
            pc1   <= 32'h0;
            inst0 <= NOP_INST;
            inst1 <= NOP_INST;
            cnt   <= 2'd0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            // Slot 0 is left untouched when the queue drains so the outputs hold.
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        pc0   <= push_pc;
                        inst0 <= push_inst;
                    end else begin
                        pc1   <= push_pc;
                        inst1 <= push_inst;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    if (cnt == 2'd2) begin
                        pc0   <= pc1;
                        inst0 <= inst1;
                    end
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        pc0   <= pc1;
                        inst0 <= inst1;
                        pc1   <= push_pc;
                        inst1 <= push_inst;
                    end else begin
                        pc0   <= push_pc;
                        inst0 <= push_inst;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_pc   = pc0;
    assign head_inst = inst0;
    assign count     = cnt;
endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - PC owner and fetch sequencer for the combinational ROM
// Optional ROM bound check (halt + fault) enabled by IF_BOUND_CHECK_EN.
module inst_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [31:0]       out_pc,
    output logic              fault
);
    logic [31:0]  pc;
    fetch_state_t state;
    logic         fault_q;
    logic [1:0]   count;
    logic         pop, push_req, push, oob;
    logic [31:0]  target;

    assign target   = redirect_pc & ~32'h3;
    assign pop      = out_valid & out_ready;
    assign push_req = (state == RUN) & ~redirect_valid & (~count[1] | pop);

`ifdef IF_BOUND_CHECK_EN
    assign oob = ({2'b00, pc_word_idx(pc)} >= 32'(ROM_WORDS));
`else
    assign oob = 1'b0;
`endif

    assign push      = push_req & ~oob;
    assign rom_addr  = pc;
    assign out_valid = (count != 2'd0) & ~redirect_valid;
    assign fault     = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            state   <= RUN;
            fault_q <= 1'b0;
        end else begin
            if (redirect_valid)
                pc <= target;
            else if (push)
                pc <= pc + 32'd4;
            // An out-of-range fetch attempt parks the sequencer until reset.
            if (push_req & oob) begin
                state   <= HALT;
                fault_q <= 1'b1;
            end
        end
    end

    fetch_queue2 u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop & ~redirect_valid),
        .flush     (redirect_valid),
        .push_pc   (pc),
        .push_inst (rom_inst),
        .head_pc   (out_pc),
        .head_inst (out_inst),
        .count     (count)
    );
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - self-checking bench with ROM model and stream scoreboard
module tb_inst_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fault;

    int checks = 0;
    int failures = 0;

    logic [31:0] rom [0:31];
    logic [31:0] exp_pc;
    logic [31:0] last_pc;
    logic        seen80;

    assign rom_inst = rom[rom_addr[6:2]];

    always #5 clk = ~clk;

    inst_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then score the handshake the next
    // rising edge will perform against the architectural instruction stream.
    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (rv) begin
            check("redirect_blocks_valid", {31'h0, out_valid}, 32'h0);
            exp_pc = {rpc[31:2], 2'b00};
        end else if (out_valid && rdy) begin
            check("stream_pc", out_pc, exp_pc);
            check("stream_inst", out_inst, rom[exp_pc[6:2]]);
            last_pc = out_pc;
            exp_pc  = exp_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_inst", out_inst, 32'h0);
        check("rst_rom_addr", rom_addr, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom | 32'h1;
        rom[0] = 32'h0800_0005;
        rom[5] = 32'h3401_1234;
        exp_pc  = 32'h0;
        last_pc = 32'h0;
        seen80  = 1'b0;

        // Straight-line fetch, one instruction per cycle.
        do_reset();
        cyc(1'b1, 1'b0, 32'h0);
        check("first_valid", {31'h0, out_valid}, 32'h1);
        check("first_inst", out_inst, 32'h0800_0005);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            check("no_bubble", {31'h0, out_valid}, 32'h1);
        end

        // Back-pressure: queue saturates, pc holds, then drains in order.
        do_reset();
        repeat (5) cyc(1'b0, 1'b0, 32'h0);
        check("bp_rom_addr", rom_addr, 32'h8);
        check("bp_valid", {31'h0, out_valid}, 32'h1);
        check("bp_head", out_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            check("drain_valid", {31'h0, out_valid}, 32'h1);
        end
        check("drain_last", last_pc, 32'h8);

        // Redirect with full queue: two empty cycles, then the target.
        repeat (3) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h14);
        check("redir_rom_addr", rom_addr, 32'h14);
        cyc(1'b1, 1'b0, 32'h0);
        check("redir_gap", {31'h0, out_valid}, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        check("redir_tgt_pc", last_pc, 32'h14);
        check("redir_tgt_inst", out_inst, 32'h3401_1234);

        // Misaligned redirect while decode is ready: nothing popped, target aligned.
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h17);
        cyc(1'b1, 1'b0, 32'h0);
        check("mis_gap", {31'h0, out_valid}, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        check("mis_tgt_pc", last_pc, 32'h14);

        // Randomized ready and periodic low-address redirects.
        for (int i = 0; i < 200; i++) begin
            if ((i % 8) == 7)
                cyc(($urandom % 4) != 0, 1'b1, $urandom_range(0, 32'h40));
            else
                cyc(($urandom % 4) != 0, 1'b0, 32'h0);
        end
        check("rand_fault", {31'h0, fault}, 32'h0);

        // Asynchronous reset between edges.
        cyc(1'b1, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'h0, out_valid}, 32'h0);
        check("arst_rom_addr", rom_addr, 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = 32'h0;
        cyc(1'b1, 1'b0, 32'h0);
        check("arst_restart", out_pc, 32'h0);
        check("arst_restart_v", {31'h0, out_valid}, 32'h1);

        // Free-run past the end of the ROM.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            if (out_valid && out_pc == 32'h80) begin
                seen80 = 1'b1;
                check("alias_inst", out_inst, rom[0]);
            end
        end
`ifdef IF_BOUND_CHECK_EN
        check("bound_last_pc", last_pc, 32'h7C);
        check("bound_rom_addr", rom_addr, 32'h80);
        check("bound_fault", {31'h0, fault}, 32'h1);
        check("bound_valid", {31'h0, out_valid}, 32'h0);
        repeat (5) cyc(1'b1, 1'b0, 32'h0);
        check("bound_fault_sticky", {31'h0, fault}, 32'h1);
`else
        check("alias_seen", {31'h0, seen80}, 32'h1);
        check("alias_fault", {31'h0, fault}, 32'h0);
`endif
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
